// File: rtl/merge_nx1_rr_sched_if.sv
// Handshake bundle for the N-to-1 round-robin merge node.
// Carries the per-input valid/data/ready, the registered output and grant status.
interface merge_nx1_rr_sched_if #(
    parameter int NUM_IN     = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_IN-1:0]            i_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus;
    logic [NUM_IN-1:0]            o_ready;
    logic                         o_valid;
    logic [DATA_WIDTH-1:0]        o_data_bus;
    logic                         i_ready;
    logic [NUM_IN-1:0]            o_grant;
    logic                         o_busy;

    modport master (
        output i_valid, i_data_bus, i_ready,
        input  o_ready, o_valid, o_data_bus, o_grant, o_busy
    );

    modport slave (
        input  i_valid, i_data_bus, i_ready,
        output o_ready, o_valid, o_data_bus, o_grant, o_busy
    );
endinterface

// File: rtl/merge_nx1_rr_sched.sv
// Round-robin burst scheduler and registered merge for an N-to-1 NoC node.
// Ports: clk, rst (sync, high), i_en (freeze when 0), bus (slave modport).
module merge_nx1_rr_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 2,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    merge_nx1_rr_sched_if.slave bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e                state_q, state_d;
    logic [NUM_IN-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [DATA_WIDTH-1:0] lane [NUM_IN];
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  take;
    logic                  lock;
    logic [NUM_IN-1:0]     ready;
    logic                  accept;
    logic                  last_beat;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            lane[k] = bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid input after last_q, searching upward with wrap.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jx;
        j          = 0;
        jx         = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            j = int'(last_q) + k;
            if (j >= NUM_IN) begin
                j = j - NUM_IN;
            end
            jx = IDX_W'(j);
            if (!pick_found && bus.i_valid[jx]) begin
                pick_found = 1'b1;
                pick_idx   = jx;
            end
        end
    end

    assign take      = !valid_q || bus.i_ready;
    assign lock      = (state_q == LOCK);
    assign ready     = grant_q & {NUM_IN{take && i_en && lock}};
    assign accept    = |(ready & bus.i_valid);
    assign last_beat = (cnt_q == CNT_WIDTH'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (i_en) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        gidx_d            = pick_idx;
                        cnt_d             = '0;
                        state_d           = LOCK;
                    end
                end
                LOCK: begin
                    // A dropped valid or a full burst hands the grant on.
                    if (!bus.i_valid[gidx_q] || (accept && last_beat)) begin
                        last_d  = gidx_q;
                        grant_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (accept) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            // take guarantees the old beat drains on any accept.
            if (accept) begin
                valid_d = 1'b1;
                data_d  = lane[gidx_q];
            end else if (bus.i_ready && valid_q) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_IN - 1);
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_data_bus = data_q;
    assign bus.o_grant    = grant_q;
    assign bus.o_busy     = lock;
endmodule

// File: tb/tb_merge_nx1_rr_sched.sv
// Directed bench for merge_nx1_rr_sched, NUM_IN=2, BURST_LEN=4.
// Vectors are hand-computed per clock edge; outputs sampled 1ns after posedge.
module tb_merge_nx1_rr_sched;
    localparam int DW = 32;
    localparam int NI = 2;

    localparam logic [31:0] LA = 32'hAAAA_AAAA;
    localparam logic [31:0] LB = 32'hBBBB_BBBB;

    logic clk;
    logic rst;
    logic i_en;
    int   nvec;
    int   nerr;

    merge_nx1_rr_sched_if #(.NUM_IN(NI), .DATA_WIDTH(DW)) bus ();

    merge_nx1_rr_sched #(
        .DATA_WIDTH(DW),
        .NUM_IN    (NI),
        .BURST_LEN (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .i_en(i_en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [31:0] l0,
                             input logic [31:0] l1);
        bus.i_data_bus = {l1, l0};
    endtask

    task automatic do_reset(input logic [1:0] v);
        rst         = 1'b1;
        i_en        = 1'b1;
        bus.i_ready = 1'b1;
        bus.i_valid = v;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic        ev [10];
    logic [31:0] ed [10];
    logic [1:0]  eg [10];

    initial begin
        nvec = 0;
        nerr = 0;
        set_lanes(LA, LB);

        // Reset with both inputs requesting.
        do_reset(2'b11);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_grant", 32'(bus.o_grant), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_data", bus.o_data_bus, 32'd0);
        tick();
        check("first_grant", 32'(bus.o_grant), 32'd1);
        check("first_ready", 32'(bus.o_ready), 32'd1);

        // Continuous two-input burst rotation.
        ev = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        ed = '{LA, LA, LA, LA, LA, LB, LB, LB, LB, LB};
        eg = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
               2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("rr_v%0d", i), 32'(bus.o_valid), 32'(ev[i]));
            check($sformatf("rr_d%0d", i), bus.o_data_bus, ed[i]);
            check($sformatf("rr_g%0d", i), 32'(bus.o_grant), 32'(eg[i]));
        end

        // Lane1 alone for three beats, then drops.
        do_reset(2'b10);
        tick();
        check("l1_grant", 32'(bus.o_grant), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("l1_v%0d", i), 32'(bus.o_valid), 32'd1);
            check($sformatf("l1_d%0d", i), bus.o_data_bus, LB);
        end
        bus.i_valid = 2'b00;
        tick();
        check("l1_rel_g", 32'(bus.o_grant), 32'd0);
        check("l1_rel_busy", 32'(bus.o_busy), 32'd0);
        check("l1_rel_v", 32'(bus.o_valid), 32'd0);
        bus.i_valid = 2'b11;
        tick();
        check("l1_next_g", 32'(bus.o_grant), 32'd1);

        // Back-pressure for three cycles mid-burst.
        do_reset(2'b11);
        tick();
        tick();
        tick();
        bus.i_ready = 1'b0;
        set_lanes(32'h1111_1111, LB);
        #1;
        check("bp_ready0", 32'(bus.o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_v%0d", i), 32'(bus.o_valid), 32'd1);
            check($sformatf("bp_d%0d", i), bus.o_data_bus, LA);
            check($sformatf("bp_r%0d", i), 32'(bus.o_ready), 32'd0);
            check($sformatf("bp_g%0d", i), 32'(bus.o_grant), 32'd1);
        end
        bus.i_ready = 1'b1;
        tick();
        check("bp_b3_d", bus.o_data_bus, 32'h1111_1111);
        check("bp_b3_g", 32'(bus.o_grant), 32'd1);
        tick();
        check("bp_b4_v", 32'(bus.o_valid), 32'd1);
        check("bp_b4_g", 32'(bus.o_grant), 32'd0);
        tick();
        check("bp_bub_v", 32'(bus.o_valid), 32'd0);
        check("bp_bub_g", 32'(bus.o_grant), 32'd2);

        // Enable low for two cycles mid-burst.
        set_lanes(LA, LB);
        do_reset(2'b11);
        tick();
        tick();
        tick();
        i_en = 1'b0;
        set_lanes(32'h2222_2222, LB);
        #1;
        check("en_ready0", 32'(bus.o_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("en_v%0d", i), 32'(bus.o_valid), 32'd1);
            check($sformatf("en_d%0d", i), bus.o_data_bus, LA);
            check($sformatf("en_g%0d", i), 32'(bus.o_grant), 32'd1);
            check($sformatf("en_b%0d", i), 32'(bus.o_busy), 32'd1);
        end
        i_en = 1'b1;
        tick();
        check("en_b3_d", bus.o_data_bus, 32'h2222_2222);
        check("en_b3_g", 32'(bus.o_grant), 32'd1);
        tick();
        check("en_b4_g", 32'(bus.o_grant), 32'd0);
        check("en_b4_v", 32'(bus.o_valid), 32'd1);
        tick();
        check("en_bub_g", 32'(bus.o_grant), 32'd2);
        check("en_bub_v", 32'(bus.o_valid), 32'd0);

        // Reset after beat 2 of a lane0 burst.
        set_lanes(LA, LB);
        do_reset(2'b11);
        tick();
        tick();
        tick();
        check("mr_pre_v", 32'(bus.o_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mr_v", 32'(bus.o_valid), 32'd0);
        check("mr_g", 32'(bus.o_grant), 32'd0);
        check("mr_d", bus.o_data_bus, 32'd0);
        rst = 1'b0;
        tick();
        check("mr_next_g", 32'(bus.o_grant), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
